// File: rtl/fsm_d_decoder_pkg.sv
// Shared definitions for the fsm_d encoder/decoder pair: state codes,
// decoder FSM states and the single next-state table both sides use.
package fsm_d_decoder_pkg;

    localparam int SYM_W = 3;

    typedef logic [SYM_W-1:0] sym_t;

    localparam sym_t S000 = 3'b000;
    localparam sym_t S001 = 3'b001;
    localparam sym_t S010 = 3'b010;
    localparam sym_t S011 = 3'b011;
    localparam sym_t S100 = 3'b100;
    localparam sym_t S101 = 3'b101;
    localparam sym_t S110 = 3'b110;
    localparam sym_t S111 = 3'b111;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } dec_state_e;

    // Encoder next-state table: the state reached from s when input bit x is applied.
    function automatic sym_t fsm_d_next(input sym_t s, input logic x);
        sym_t ns;
        case (s)
            S000: ns = x ? S001 : S000;
            S001: ns = x ? S011 : S010;
            S010: ns = x ? S011 : S010;
            S011: ns = x ? S111 : S110;
            S100: ns = x ? S101 : S100;
            S101: ns = x ? S000 : S001;
            S110: ns = x ? S111 : S110;
            S111: ns = x ? S000 : S001;
        endcase
        return ns;
    endfunction

endpackage

// File: rtl/fsm_d_step_check.sv
// Combinational transition checker: decides whether prev -> sym is a legal
// encoder step and, if so, which input bit produced it.
module fsm_d_step_check
    import fsm_d_decoder_pkg::*;
(
    input  logic [SYM_W-1:0] prev_i,
    input  logic [SYM_W-1:0] sym_i,
    output logic             legal_o,
    output logic             x_o
);

    sym_t ns_one;
    sym_t ns_zero;

    // Compare the received code against both possible successors of prev_i.
    always_comb begin
        ns_one  = fsm_d_next(prev_i, 1'b1);
        ns_zero = fsm_d_next(prev_i, 1'b0);
        x_o     = (sym_i == ns_one);
        legal_o = x_o || (sym_i == ns_zero);
    end

endmodule

// File: rtl/fsm_d_decoder.sv
// fsm_d receive-side decoder: validates each state transition, locks onto
// the stream, packs recovered bits LSB-first into words, offers them over a
// one-deep valid/ready register and counts illegal transitions.
module fsm_d_decoder
    import fsm_d_decoder_pkg::*;
#(
    parameter int WORD_W   = 8,
    parameter int LOCK_CNT = 2,
    parameter int ERRC_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sym_valid,
    input  logic [SYM_W-1:0]  sym,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              locked,
    output logic              err_pulse,
    output logic [ERRC_W-1:0] err_count,
    output logic              overflow
);

    localparam int BIT_W  = $clog2(WORD_W);
    localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
    localparam logic [GOOD_W-1:0] LAST_GOOD = GOOD_W'(LOCK_CNT - 1);

    dec_state_e        state_q, state_d;
    sym_t              prev_q, prev_d;
    logic              prev_valid_q, prev_valid_d;
    logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              out_valid_q, out_valid_d;
    logic [WORD_W-1:0] out_data_q, out_data_d;
    logic              err_pulse_q, err_pulse_d;
    logic [ERRC_W-1:0] err_count_q, err_count_d;
    logic              overflow_q, overflow_d;

    logic step_legal;
    logic step_x;
    logic word_done;
    logic err_hit;

    fsm_d_step_check u_step_check (
        .prev_i  (prev_q),
        .sym_i   (sym),
        .legal_o (step_legal),
        .x_o     (step_x)
    );

    // Next-state logic: transition decision, HUNT/LOCKED FSM, bit packing and output hand-off.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path can infer a latch.
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        good_cnt_d   = good_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        out_valid_d  = out_valid_q && !out_ready;
        out_data_d   = out_data_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        overflow_d   = overflow_q;
        word_done    = 1'b0;
        err_hit      = 1'b0;

        if (sym_valid) begin
            // The decoder always follows the received code so it resyncs after an error.
            prev_d       = sym;
            prev_valid_d = 1'b1;

            if (prev_valid_q) begin
                case (state_q)
                    ST_HUNT: begin
                        if (step_legal) begin
                            // The bit of the locking transition itself is discarded.
                            if (good_cnt_q == LAST_GOOD) begin
                                state_d    = ST_LOCKED;
                                good_cnt_d = '0;
                            end else begin
                                good_cnt_d = good_cnt_q + 1'b1;
                            end
                        end else begin
                            good_cnt_d = '0;
                            err_hit    = 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (step_legal) begin
                            shreg_d[bit_cnt_q] = step_x;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_d = '0;
                                word_done = 1'b1;
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end else begin
                            bit_cnt_d = '0;
                            state_d   = ST_HUNT;
                            err_hit   = 1'b1;
                        end
                    end
                    default: state_d = ST_HUNT;
                endcase
            end
        end

        if (err_hit) begin
            err_pulse_d = 1'b1;
            if (err_count_q != '1) begin
                err_count_d = err_count_q + 1'b1;
            end
        end

        // A finished word replaces the held one only if that slot is free or being taken now.
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                out_data_d  = shreg_d;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State register: asynchronous clear of every register, including counters and sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            prev_q       <= S000;
            prev_valid_q <= 1'b0;
            good_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            // NOTE: the shift register is cleared as well, so a word is never built from X bits.
            shreg_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from the old values.
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            good_cnt_q   <= good_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_fsm_d_decoder.sv
// Directed bench for fsm_d_decoder: table-driven symbol vectors with
// hand-computed expected outputs, plus hand-written reset and saturation sequences.
module tb_fsm_d_decoder;

    localparam int WORD_W = 8;
    localparam int ERRC_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sym_valid;
    logic [2:0]        sym;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;
    logic              locked;
    logic              err_pulse;
    logic [ERRC_W-1:0] err_count;
    logic              overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       sv;
        logic [2:0] s;
        logic       rdy;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_locked;
        logic       e_err;
        logic [7:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vq[$];

    fsm_d_decoder #(
        .WORD_W   (WORD_W),
        .LOCK_CNT (2),
        .ERRC_W   (ERRC_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sym_valid (sym_valid),
        .sym       (sym),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [7:0] ed,
                                 input logic el, input logic ee, input logic [7:0] ec,
                                 input logic eo);
        check({tag, ".out_valid"}, out_valid, ev);
        check({tag, ".out_data"},  out_data,  ed);
        check({tag, ".locked"},    locked,    el);
        check({tag, ".err_pulse"}, err_pulse, ee);
        check({tag, ".err_count"}, err_count, ec);
        check({tag, ".overflow"},  overflow,  eo);
    endtask

    task automatic add(input logic sv, input logic [2:0] s, input logic rdy,
                       input logic ev, input logic [7:0] ed, input logic el,
                       input logic ee, input logic [7:0] ec, input logic eo);
        vec_t v;
        v.sv = sv; v.s = s; v.rdy = rdy;
        v.e_valid = ev; v.e_data = ed; v.e_locked = el;
        v.e_err = ee; v.e_cnt = ec; v.e_ovf = eo;
        vq.push_back(v);
    endtask

    // Apply one vector per clock, then compare outputs 1 time unit after the edge.
    task automatic run_vectors(input string tag);
        foreach (vq[i]) begin
            sym_valid = vq[i].sv;
            sym       = vq[i].s;
            out_ready = vq[i].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("%s[%0d]", tag, i), vq[i].e_valid, vq[i].e_data,
                          vq[i].e_locked, vq[i].e_err, vq[i].e_cnt, vq[i].e_ovf);
        end
        vq.delete();
    endtask

    initial begin
        logic [2:0] t1  [7] = '{3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        logic [2:0] t3a [4] = '{3'b111, 3'b000, 3'b001, 3'b011};
        logic [2:0] t3b [7] = '{3'b011, 3'b110, 3'b111, 3'b000, 3'b000, 3'b000, 3'b001};
        logic [2:0] t5  [7] = '{3'b011, 3'b111, 3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
        int exp_cnt;

        reset_n   = 1'b0;
        sym_valid = 1'b0;
        sym       = 3'b000;
        out_ready = 1'b0;
        #2;
        check_outputs("in_reset", 0, 8'h00, 0, 0, 8'h00, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_outputs("after_reset", 0, 8'h00, 0, 0, 8'h00, 0);

        // x=1 stream: lock after the 3rd symbol, word 8'hFF one cycle after the 11th.
        add(1, 3'b000, 0, 0, 8'h00, 0, 0, 8'd0, 0);
        add(1, 3'b001, 0, 0, 8'h00, 0, 0, 8'd0, 0);
        add(1, 3'b011, 0, 0, 8'h00, 1, 0, 8'd0, 0);
        foreach (t1[i]) add(1, t1[i], 0, 0, 8'h00, 1, 0, 8'd0, 0);
        add(1, 3'b011, 0, 1, 8'hFF, 1, 0, 8'd0, 0);
        add(0, 3'b000, 1, 0, 8'hFF, 1, 0, 8'd0, 0);
        run_vectors("t1_ones");

        // Four bits into a word, then 011 -> 100 is illegal: drop partial word, back to HUNT.
        foreach (t3a[i]) add(1, t3a[i], 0, 0, 8'hFF, 1, 0, 8'd0, 0);
        add(1, 3'b100, 0, 0, 8'hFF, 0, 1, 8'd1, 0);
        add(1, 3'b101, 0, 0, 8'hFF, 0, 0, 8'd1, 0);
        add(1, 3'b001, 0, 0, 8'hFF, 1, 0, 8'd1, 0);
        // Full 8 bits 1,0,1,1,0,0,1,0 (LSB first) -> 8'h4D; early completion would expose a kept bit count.
        foreach (t3b[i]) add(1, t3b[i], 0, 0, 8'hFF, 1, 0, 8'd1, 0);
        add(1, 3'b010, 0, 1, 8'h4D, 1, 0, 8'd1, 0);
        run_vectors("t3_err_relock");

        // Word completes while the held word is being accepted: replace, stay valid, no overflow.
        foreach (t5[i]) add(1, t5[i], 0, 1, 8'h4D, 1, 0, 8'd1, 0);
        add(1, 3'b001, 1, 1, 8'hFF, 1, 0, 8'd1, 0);
        run_vectors("t5_accept_and_load");

        // Consumer stalled: the next completed word (all zeros) is dropped and overflow sticks.
        for (int i = 0; i < 7; i++) add(1, 3'b010, 0, 1, 8'hFF, 1, 0, 8'd1, 0);
        add(1, 3'b010, 0, 1, 8'hFF, 1, 0, 8'd1, 1);
        for (int i = 0; i < 5; i++) add(1, 3'b010, 0, 1, 8'hFF, 1, 0, 8'd1, 1);
        run_vectors("t4_overflow");

        // Reset mid-word (bit count 5), away from any clock edge: everything clears at once.
        sym_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("t6_async_reset", 0, 8'h00, 0, 0, 8'h00, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        // First symbol after reset (100) is not judged against the reset prev value.
        add(1, 3'b100, 0, 0, 8'h00, 0, 0, 8'd0, 0);
        add(1, 3'b100, 0, 0, 8'h00, 0, 0, 8'd0, 0);
        add(1, 3'b100, 0, 0, 8'h00, 1, 0, 8'd0, 0);
        run_vectors("t6_after_reset");

        // x=0 stream from reset: lock after 3 symbols, 8'h00 word after 8 further ones.
        sym_valid = 1'b0;
        reset_n   = 1'b0;
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 11; i++) begin
            add(1, 3'b000, 0, (i == 10), 8'h00, (i >= 2), 0, 8'd0, 0);
        end
        run_vectors("t2_zeros");

        // Alternating 100/000 is illegal every step: err_count must stop at all-ones.
        for (int i = 0; i < 260; i++) begin
            sym_valid = 1'b1;
            sym       = (i % 2 == 0) ? 3'b100 : 3'b000;
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            if (i == 0) check("sat_unlock.locked", locked, 1'b0);
            if (i >= 253) begin
                exp_cnt = (i + 1 > 255) ? 255 : i + 1;
                check($sformatf("sat[%0d].err_pulse", i), err_pulse, 1'b1);
                check($sformatf("sat[%0d].err_count", i), err_count, exp_cnt);
            end
        end
        sym_valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat_idle.err_pulse", err_pulse, 1'b0);
        check("sat_idle.err_count", err_count, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
